// File: rtl/axi_lite_arbiter_if.sv
// AXI-Lite channel bundle; the arbiter takes an array of these as hosts and one as its device.
interface axi_lite_channel #(
    parameter int unsigned ADDR_WIDTH = 48,
    parameter int unsigned DATA_WIDTH = 64
) ();
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  aw_valid;
    logic                  aw_ready;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [2:0]            aw_prot;
    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  b_valid;
    logic                  b_ready;
    logic [1:0]            b_resp;
    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [2:0]            ar_prot;
    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;

    modport master (
        output aw_valid, aw_addr, aw_prot, input aw_ready,
        output w_valid, w_data, w_strb, input w_ready,
        input b_valid, b_resp, output b_ready,
        output ar_valid, ar_addr, ar_prot, input ar_ready,
        input r_valid, r_data, r_resp, output r_ready
    );

    modport slave (
        input aw_valid, aw_addr, aw_prot, output aw_ready,
        input w_valid, w_data, w_strb, output w_ready,
        output b_valid, b_resp, input b_ready,
        input ar_valid, ar_addr, ar_prot, output ar_ready,
        output r_valid, r_data, r_resp, input r_ready
    );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite slave among NUM_MASTERS hosts.
// Write and read paths arbitrate independently, one outstanding transaction each.
module axi_lite_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_WIDTH  = 48,
    parameter int unsigned DATA_WIDTH  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_lite_channel.slave         host [NUM_MASTERS],
    axi_lite_channel.master        device,
    output logic [NUM_MASTERS-1:0] wr_owner,
    output logic [NUM_MASTERS-1:0] rd_owner
);
    localparam int unsigned N          = NUM_MASTERS;
    localparam int unsigned IDXW       = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    if (NUM_MASTERS < 2) begin : g_bad_num_masters
        $fatal(1, "axi_lite_arbiter: NUM_MASTERS must be at least 2");
    end
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
        $fatal(1, "axi_lite_arbiter: DATA_WIDTH must be 32 or 64");
    end

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} rd_state_e;

    logic [N-1:0]          aw_valid_h, w_valid_h, b_ready_h, ar_valid_h, r_ready_h;
    logic [ADDR_WIDTH-1:0] aw_addr_h [N];
    logic [ADDR_WIDTH-1:0] ar_addr_h [N];
    logic [2:0]            aw_prot_h [N];
    logic [2:0]            ar_prot_h [N];
    logic [DATA_WIDTH-1:0] w_data_h  [N];
    logic [STRB_WIDTH-1:0] w_strb_h  [N];

    wr_state_e       wr_state_q;
    logic [IDXW-1:0] wr_gnt_q, wr_ptr_q, wr_pick;
    logic [N-1:0]    wr_owner_q;
    logic            aw_done_q, w_done_q;
    logic            dev_aw_valid_c, dev_w_valid_c, dev_b_ready_c;
    logic            aw_hs, w_hs, b_hs;

    rd_state_e       rd_state_q;
    logic [IDXW-1:0] rd_gnt_q, rd_ptr_q, rd_pick;
    logic [N-1:0]    rd_owner_q;
    logic            dev_ar_valid_c, dev_r_ready_c;
    logic            ar_hs, r_hs;

    // First requester at or above ptr, wrapping modulo N.
    function automatic logic [IDXW-1:0] rr_pick(input logic [N-1:0] req, input logic [IDXW-1:0] ptr);
        logic [IDXW-1:0] pick;
        logic            found;
        int unsigned     idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[IDXW'(idx)]) begin
                pick  = IDXW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] v);
        return (v == IDXW'(N - 1)) ? '0 : v + IDXW'(1);
    endfunction

    // Flatten the host interface array into indexable vectors and drive gated responses back.
    for (genvar g = 0; g < N; g++) begin : g_host
        assign aw_valid_h[g] = host[g].aw_valid;
        assign aw_addr_h[g]  = host[g].aw_addr;
        assign aw_prot_h[g]  = host[g].aw_prot;
        assign w_valid_h[g]  = host[g].w_valid;
        assign w_data_h[g]   = host[g].w_data;
        assign w_strb_h[g]   = host[g].w_strb;
        assign b_ready_h[g]  = host[g].b_ready;
        assign ar_valid_h[g] = host[g].ar_valid;
        assign ar_addr_h[g]  = host[g].ar_addr;
        assign ar_prot_h[g]  = host[g].ar_prot;
        assign r_ready_h[g]  = host[g].r_ready;

        assign host[g].aw_ready = wr_owner_q[g] && (wr_state_q == W_ADDR) && !aw_done_q && device.aw_ready;
        assign host[g].w_ready  = wr_owner_q[g] && (wr_state_q == W_ADDR) && !w_done_q && device.w_ready;
        assign host[g].b_valid  = wr_owner_q[g] && (wr_state_q == W_RESP) && device.b_valid;
        assign host[g].b_resp   = (wr_owner_q[g] && (wr_state_q == W_RESP) && device.b_valid) ? device.b_resp : 2'b00;
        assign host[g].ar_ready = rd_owner_q[g] && (rd_state_q == R_ADDR) && device.ar_ready;
        assign host[g].r_valid  = rd_owner_q[g] && (rd_state_q == R_RESP) && device.r_valid;
        assign host[g].r_resp   = (rd_owner_q[g] && (rd_state_q == R_RESP) && device.r_valid) ? device.r_resp : 2'b00;
        assign host[g].r_data   = (rd_owner_q[g] && (rd_state_q == R_RESP) && device.r_valid) ? device.r_data : '0;
    end

    assign wr_pick = rr_pick(aw_valid_h, wr_ptr_q);
    assign rd_pick = rr_pick(ar_valid_h, rd_ptr_q);

    // Once a channel has handshaken its forwarded valid stays low until the response completes.
    assign dev_aw_valid_c = (wr_state_q == W_ADDR) && !aw_done_q && aw_valid_h[wr_gnt_q];
    assign dev_w_valid_c  = (wr_state_q == W_ADDR) && !w_done_q && w_valid_h[wr_gnt_q];
    assign dev_b_ready_c  = (wr_state_q == W_RESP) && b_ready_h[wr_gnt_q];
    assign aw_hs          = dev_aw_valid_c && device.aw_ready;
    assign w_hs           = dev_w_valid_c && device.w_ready;
    assign b_hs           = dev_b_ready_c && device.b_valid;

    assign dev_ar_valid_c = (rd_state_q == R_ADDR) && ar_valid_h[rd_gnt_q];
    assign dev_r_ready_c  = (rd_state_q == R_RESP) && r_ready_h[rd_gnt_q];
    assign ar_hs          = dev_ar_valid_c && device.ar_ready;
    assign r_hs           = dev_r_ready_c && device.r_valid;

    assign device.aw_valid = dev_aw_valid_c;
    assign device.aw_addr  = aw_addr_h[wr_gnt_q];
    assign device.aw_prot  = aw_prot_h[wr_gnt_q];
    assign device.w_valid  = dev_w_valid_c;
    assign device.w_data   = w_data_h[wr_gnt_q];
    assign device.w_strb   = w_strb_h[wr_gnt_q];
    assign device.b_ready  = dev_b_ready_c;
    assign device.ar_valid = dev_ar_valid_c;
    assign device.ar_addr  = ar_addr_h[rd_gnt_q];
    assign device.ar_prot  = ar_prot_h[rd_gnt_q];
    assign device.r_ready  = dev_r_ready_c;

    assign wr_owner = wr_owner_q;
    assign rd_owner = rd_owner_q;

    // Write path FSM; AW alone requests, W is only followed once granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            wr_gnt_q   <= '0;
            wr_ptr_q   <= '0;
            wr_owner_q <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (|aw_valid_h) begin
                        wr_gnt_q   <= wr_pick;
                        wr_owner_q <= N'(1) << wr_pick;
                        wr_state_q <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) wr_state_q <= W_RESP;
                end
                W_RESP: begin
                    if (b_hs) begin
                        wr_ptr_q   <= wrap_inc(wr_gnt_q);
                        wr_owner_q <= '0;
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // Read path FSM, independent of the write path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_gnt_q   <= '0;
            rd_ptr_q   <= '0;
            rd_owner_q <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (|ar_valid_h) begin
                        rd_gnt_q   <= rd_pick;
                        rd_owner_q <= N'(1) << rd_pick;
                        rd_state_q <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (ar_hs) rd_state_q <= R_RESP;
                end
                R_RESP: begin
                    if (r_hs) begin
                        rd_ptr_q   <= wrap_inc(rd_gnt_q);
                        rd_owner_q <= '0;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter with four hosts and a scripted device.
module tb_axi_lite_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 48;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = DW / 8;

    logic clk, rst;

    logic [N-1:0]  h_aw_valid, h_w_valid, h_b_ready, h_ar_valid, h_r_ready;
    logic [AW-1:0] h_aw_addr [N];
    logic [AW-1:0] h_ar_addr [N];
    logic [2:0]    h_aw_prot [N];
    logic [2:0]    h_ar_prot [N];
    logic [DW-1:0] h_w_data  [N];
    logic [SW-1:0] h_w_strb  [N];
    logic [N-1:0]  h_aw_ready, h_w_ready, h_b_valid, h_ar_ready, h_r_valid;
    logic [1:0]    h_b_resp [N];
    logic [1:0]    h_r_resp [N];
    logic [DW-1:0] h_r_data [N];

    logic          d_aw_ready, d_w_ready, d_b_valid, d_ar_ready, d_r_valid;
    logic [1:0]    d_b_resp, d_r_resp;
    logic [DW-1:0] d_r_data;

    logic [N-1:0]  wr_owner, rd_owner;

    int checks;
    int failures;
    int unsigned aw_hs_cnt, w_hs_cnt, host_b_cnt;

    axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) host_if [N] ();
    axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) device_if ();

    for (genvar g = 0; g < N; g++) begin : g_host
        assign host_if[g].aw_valid = h_aw_valid[g];
        assign host_if[g].aw_addr  = h_aw_addr[g];
        assign host_if[g].aw_prot  = h_aw_prot[g];
        assign host_if[g].w_valid  = h_w_valid[g];
        assign host_if[g].w_data   = h_w_data[g];
        assign host_if[g].w_strb   = h_w_strb[g];
        assign host_if[g].b_ready  = h_b_ready[g];
        assign host_if[g].ar_valid = h_ar_valid[g];
        assign host_if[g].ar_addr  = h_ar_addr[g];
        assign host_if[g].ar_prot  = h_ar_prot[g];
        assign host_if[g].r_ready  = h_r_ready[g];
        assign h_aw_ready[g] = host_if[g].aw_ready;
        assign h_w_ready[g]  = host_if[g].w_ready;
        assign h_b_valid[g]  = host_if[g].b_valid;
        assign h_b_resp[g]   = host_if[g].b_resp;
        assign h_ar_ready[g] = host_if[g].ar_ready;
        assign h_r_valid[g]  = host_if[g].r_valid;
        assign h_r_resp[g]   = host_if[g].r_resp;
        assign h_r_data[g]   = host_if[g].r_data;
    end

    assign device_if.aw_ready = d_aw_ready;
    assign device_if.w_ready  = d_w_ready;
    assign device_if.b_valid  = d_b_valid;
    assign device_if.b_resp   = d_b_resp;
    assign device_if.ar_ready = d_ar_ready;
    assign device_if.r_valid  = d_r_valid;
    assign device_if.r_resp   = d_r_resp;
    assign device_if.r_data   = d_r_data;

    axi_lite_arbiter #(
        .NUM_MASTERS(N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .host    (host_if),
        .device  (device_if),
        .wr_owner(wr_owner),
        .rd_owner(rd_owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Handshake counters sampled on the active edge.
    always @(posedge clk) begin
        if (device_if.aw_valid && device_if.aw_ready) aw_hs_cnt <= aw_hs_cnt + 1;
        if (device_if.w_valid && device_if.w_ready)   w_hs_cnt  <= w_hs_cnt + 1;
        if ((h_b_valid & h_b_ready) != '0)            host_b_cnt <= host_b_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        h_aw_valid = '0; h_w_valid = '0; h_b_ready = '0; h_ar_valid = '0; h_r_ready = '0;
        for (int i = 0; i < N; i++) begin
            h_aw_addr[i] = '0; h_ar_addr[i] = '0; h_aw_prot[i] = '0; h_ar_prot[i] = '0;
            h_w_data[i]  = '0; h_w_strb[i]  = '0;
        end
        d_aw_ready = 1'b0; d_w_ready = 1'b0; d_b_valid = 1'b0; d_ar_ready = 1'b0; d_r_valid = 1'b0;
        d_b_resp = 2'b00; d_r_resp = 2'b00; d_r_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        h_aw_valid = '1; h_w_valid = '1; h_ar_valid = '1; h_b_ready = '1; h_r_ready = '1;
        for (int i = 0; i < N; i++) begin
            h_aw_addr[i] = AW'(32'h1000 + 32'(i) * 32'h10);
            h_ar_addr[i] = AW'(32'h2000 + 32'(i) * 32'h10);
        end
        d_aw_ready = 1'b1; d_w_ready = 1'b1; d_ar_ready = 1'b1; d_b_valid = 1'b1; d_r_valid = 1'b1;
        tick(); tick(); #1;
        checks++;
        if ({device_if.aw_valid, device_if.w_valid, device_if.ar_valid, device_if.b_ready, device_if.r_ready} !== 5'b0) begin
            failures++;
            $display("FAIL reset_dev_valids got=%b exp=00000", {device_if.aw_valid, device_if.w_valid, device_if.ar_valid, device_if.b_ready, device_if.r_ready});
        end
        checks++;
        if ({h_aw_ready, h_w_ready, h_ar_ready, h_b_valid, h_r_valid} !== 20'h0) begin
            failures++;
            $display("FAIL reset_host_outputs got=%h exp=00000", {h_aw_ready, h_w_ready, h_ar_ready, h_b_valid, h_r_valid});
        end
        checks++;
        if ({wr_owner, rd_owner} !== 8'h00) begin
            failures++;
            $display("FAIL reset_owners got=%h exp=00", {wr_owner, rd_owner});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (device_if.aw_valid !== 1'b0) begin
            failures++;
            $display("FAIL release_idle_aw_valid got=%b exp=0", device_if.aw_valid);
        end
        tick(); #1;
        checks++;
        if (device_if.aw_valid !== 1'b1 || wr_owner !== 4'b0001) begin
            failures++;
            $display("FAIL release_first_write_grant aw_valid=%b owner=%b exp 1/0001", device_if.aw_valid, wr_owner);
        end
        checks++;
        if (device_if.ar_valid !== 1'b1 || rd_owner !== 4'b0001) begin
            failures++;
            $display("FAIL release_first_read_grant ar_valid=%b owner=%b exp 1/0001", device_if.ar_valid, rd_owner);
        end
        checks++;
        if (device_if.aw_addr !== 48'h1000 || device_if.ar_addr !== 48'h2000) begin
            failures++;
            $display("FAIL release_addr_host0 aw=%h ar=%h exp 1000/2000", device_if.aw_addr, device_if.ar_addr);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        h_aw_valid[1] = 1'b1; h_aw_addr[1] = 48'h40; h_aw_prot[1] = 3'b010;
        h_w_valid[1] = 1'b1; h_w_data[1] = 64'h1234; h_w_strb[1] = 8'hFF; h_b_ready[1] = 1'b1;
        d_aw_ready = 1'b1; d_w_ready = 1'b1;
        #1;
        checks++;
        if (wr_owner !== 4'b0000) begin
            failures++;
            $display("FAIL sw_idle_owner got=%b exp=0000", wr_owner);
        end
        tick(); #1;
        checks++;
        if (device_if.aw_valid !== 1'b1 || device_if.w_valid !== 1'b1 || wr_owner !== 4'b0010) begin
            failures++;
            $display("FAIL sw_addr_phase aw_v=%b w_v=%b owner=%b exp 1/1/0010", device_if.aw_valid, device_if.w_valid, wr_owner);
        end
        checks++;
        if (device_if.aw_addr !== 48'h40 || device_if.aw_prot !== 3'b010 || device_if.w_data !== 64'h1234 || device_if.w_strb !== 8'hFF) begin
            failures++;
            $display("FAIL sw_payload addr=%h prot=%b data=%h strb=%h exp 40/010/1234/ff", device_if.aw_addr, device_if.aw_prot, device_if.w_data, device_if.w_strb);
        end
        checks++;
        if (h_aw_ready !== 4'b0010 || h_w_ready !== 4'b0010) begin
            failures++;
            $display("FAIL sw_host_ready aw=%b w=%b exp 0010/0010", h_aw_ready, h_w_ready);
        end
        tick();
        h_aw_valid[1] = 1'b0; h_w_valid[1] = 1'b0;
        d_b_valid = 1'b1; d_b_resp = 2'b00;
        #1;
        checks++;
        if (device_if.b_ready !== 1'b1 || h_b_valid !== 4'b0010 || h_b_resp[1] !== 2'b00 || wr_owner !== 4'b0010) begin
            failures++;
            $display("FAIL sw_resp b_ready=%b b_valid=%b resp=%b owner=%b exp 1/0010/00/0010", device_if.b_ready, h_b_valid, h_b_resp[1], wr_owner);
        end
        tick();
        d_b_valid = 1'b0;
        #1;
        checks++;
        if (wr_owner !== 4'b0000 || device_if.b_ready !== 1'b0 || h_b_valid !== 4'b0000) begin
            failures++;
            $display("FAIL sw_done owner=%b b_ready=%b b_valid=%b exp 0000/0/0000", wr_owner, device_if.b_ready, h_b_valid);
        end
    endtask

    task automatic test_w_before_aw();
        int unsigned a0, w0;
        do_reset();
        a0 = aw_hs_cnt; w0 = w_hs_cnt;
        h_w_valid[0] = 1'b1; h_w_data[0] = 64'hA5A5; h_w_strb[0] = 8'h0F; h_b_ready[0] = 1'b1;
        d_w_ready = 1'b1; d_aw_ready = 1'b0;
        tick(); tick(); #1;
        checks++;
        if (device_if.w_valid !== 1'b0 || wr_owner !== 4'b0000) begin
            failures++;
            $display("FAIL wfirst_no_request w_valid=%b owner=%b exp 0/0000", device_if.w_valid, wr_owner);
        end
        h_aw_valid[0] = 1'b1; h_aw_addr[0] = 48'h80;
        tick(); #1;
        checks++;
        if (device_if.w_valid !== 1'b1 || device_if.aw_valid !== 1'b1 || h_w_ready !== 4'b0001 || h_aw_ready !== 4'b0000) begin
            failures++;
            $display("FAIL wfirst_addr1 w_v=%b aw_v=%b w_rdy=%b aw_rdy=%b exp 1/1/0001/0000", device_if.w_valid, device_if.aw_valid, h_w_ready, h_aw_ready);
        end
        tick(); #1;
        checks++;
        if (device_if.w_valid !== 1'b0 || h_w_ready !== 4'b0000) begin
            failures++;
            $display("FAIL wfirst_w_masked w_v=%b w_rdy=%b exp 0/0000", device_if.w_valid, h_w_ready);
        end
        checks++;
        if (device_if.aw_valid !== 1'b1 || wr_owner !== 4'b0001) begin
            failures++;
            $display("FAIL wfirst_aw_held aw_v=%b owner=%b exp 1/0001", device_if.aw_valid, wr_owner);
        end
        tick(); #1;
        checks++;
        if (device_if.b_ready !== 1'b0) begin
            failures++;
            $display("FAIL wfirst_no_early_resp b_ready=%b exp 0", device_if.b_ready);
        end
        tick();
        d_aw_ready = 1'b1;
        #1;
        checks++;
        if (h_aw_ready !== 4'b0001 || device_if.b_ready !== 1'b0) begin
            failures++;
            $display("FAIL wfirst_aw_accept aw_rdy=%b b_ready=%b exp 0001/0", h_aw_ready, device_if.b_ready);
        end
        tick();
        h_aw_valid[0] = 1'b0; h_w_valid[0] = 1'b0; d_aw_ready = 1'b0; d_b_valid = 1'b1;
        #1;
        checks++;
        if (device_if.b_ready !== 1'b1 || h_b_valid !== 4'b0001) begin
            failures++;
            $display("FAIL wfirst_resp b_ready=%b b_valid=%b exp 1/0001", device_if.b_ready, h_b_valid);
        end
        tick();
        d_b_valid = 1'b0;
        #1;
        checks++;
        if (w_hs_cnt - w0 !== 1 || aw_hs_cnt - a0 !== 1) begin
            failures++;
            $display("FAIL wfirst_hs_counts w=%0d aw=%0d exp 1/1", w_hs_cnt - w0, aw_hs_cnt - a0);
        end
        checks++;
        if (wr_owner !== 4'b0000) begin
            failures++;
            $display("FAIL wfirst_idle owner=%b exp 0000", wr_owner);
        end
    endtask

    task automatic test_round_robin();
        int order [6];
        int exp;
        logic seen;
        logic [DW-1:0] rdata;
        order = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int i = 0; i < N; i++) h_ar_addr[i] = AW'(256 * (i + 1));
        h_ar_valid = '1; h_r_ready = '1;
        d_ar_ready = 1'b1; d_r_valid = 1'b1;
        for (int t = 0; t < 6; t++) begin
            exp = order[t];
            rdata = 64'hD0D0_0000 + 64'(t);
            d_r_data = rdata;
            seen = 1'b0;
            for (int c = 0; c < 6 && !seen; c++) begin
                tick(); #1;
                if (device_if.ar_valid === 1'b1) seen = 1'b1;
            end
            checks++;
            if (!seen) begin
                failures++;
                $display("FAIL rr_timeout txn=%0d no ar_valid within 6 cycles", t);
            end else begin
                checks++;
                if (rd_owner !== 4'(1 << exp)) begin
                    failures++;
                    $display("FAIL rr_owner txn=%0d got=%b exp=%b", t, rd_owner, 4'(1 << exp));
                end
                checks++;
                if (device_if.ar_addr !== AW'(256 * (exp + 1))) begin
                    failures++;
                    $display("FAIL rr_addr txn=%0d got=%h exp=%h", t, device_if.ar_addr, AW'(256 * (exp + 1)));
                end
                tick(); #1;
                checks++;
                if (h_r_valid !== 4'(1 << exp) || h_r_data[exp] !== rdata || h_r_data[(exp + 1) % N] !== 64'h0) begin
                    failures++;
                    $display("FAIL rr_rdata txn=%0d r_valid=%b data=%h other=%h exp %b/%h/0", t, h_r_valid, h_r_data[exp], h_r_data[(exp + 1) % N], 4'(1 << exp), rdata);
                end
            end
        end
    endtask

    task automatic test_concurrent();
        do_reset();
        h_aw_valid[0] = 1'b1; h_aw_addr[0] = 48'h200; h_w_valid[0] = 1'b1; h_w_data[0] = 64'hCAFE; h_w_strb[0] = 8'hFF; h_b_ready[0] = 1'b1;
        h_ar_valid[1] = 1'b1; h_ar_addr[1] = 48'h300; h_r_ready[1] = 1'b1;
        d_aw_ready = 1'b1; d_w_ready = 1'b1; d_ar_ready = 1'b1;
        d_b_valid = 1'b1; d_b_resp = 2'b10; d_r_valid = 1'b1; d_r_resp = 2'b11; d_r_data = 64'hBEEF;
        tick(); #1;
        checks++;
        if (wr_owner !== 4'b0001 || rd_owner !== 4'b0010 || device_if.aw_valid !== 1'b1 || device_if.ar_valid !== 1'b1) begin
            failures++;
            $display("FAIL conc_addr wr=%b rd=%b aw_v=%b ar_v=%b exp 0001/0010/1/1", wr_owner, rd_owner, device_if.aw_valid, device_if.ar_valid);
        end
        checks++;
        if (device_if.aw_addr !== 48'h200 || device_if.ar_addr !== 48'h300) begin
            failures++;
            $display("FAIL conc_addr_route aw=%h ar=%h exp 200/300", device_if.aw_addr, device_if.ar_addr);
        end
        tick();
        h_aw_valid = '0; h_w_valid = '0; h_ar_valid = '0;
        #1;
        checks++;
        if (h_b_valid !== 4'b0001 || h_r_valid !== 4'b0010) begin
            failures++;
            $display("FAIL conc_resp_valid b=%b r=%b exp 0001/0010", h_b_valid, h_r_valid);
        end
        checks++;
        if (h_b_resp[0] !== 2'b10 || h_b_resp[1] !== 2'b00 || h_r_resp[1] !== 2'b11 || h_r_resp[0] !== 2'b00 || h_r_data[1] !== 64'hBEEF || h_r_data[0] !== 64'h0) begin
            failures++;
            $display("FAIL conc_resp_route b0=%b b1=%b r1=%b r0=%b d1=%h d0=%h exp 10/00/11/00/beef/0", h_b_resp[0], h_b_resp[1], h_r_resp[1], h_r_resp[0], h_r_data[1], h_r_data[0]);
        end
        tick(); #1;
        checks++;
        if (wr_owner !== 4'b0000 || rd_owner !== 4'b0000) begin
            failures++;
            $display("FAIL conc_idle wr=%b rd=%b exp 0000/0000", wr_owner, rd_owner);
        end
        h_aw_valid[2] = 1'b1; h_aw_addr[2] = 48'h400; h_w_valid[2] = 1'b1; h_w_data[2] = 64'h77; h_w_strb[2] = 8'h01; h_b_ready[2] = 1'b1;
        h_ar_valid[2] = 1'b1; h_ar_addr[2] = 48'h500; h_r_ready[2] = 1'b1;
        tick(); #1;
        checks++;
        if (wr_owner !== 4'b0100 || rd_owner !== 4'b0100 || device_if.aw_addr !== 48'h400 || device_if.ar_addr !== 48'h500) begin
            failures++;
            $display("FAIL conc_same_host_addr wr=%b rd=%b aw=%h ar=%h exp 0100/0100/400/500", wr_owner, rd_owner, device_if.aw_addr, device_if.ar_addr);
        end
        tick();
        h_aw_valid = '0; h_w_valid = '0; h_ar_valid = '0;
        #1;
        checks++;
        if (h_b_valid !== 4'b0100 || h_r_valid !== 4'b0100 || h_b_resp[2] !== 2'b10 || h_r_data[2] !== 64'hBEEF) begin
            failures++;
            $display("FAIL conc_same_host_resp b=%b r=%b bresp=%b rdata=%h exp 0100/0100/10/beef", h_b_valid, h_r_valid, h_b_resp[2], h_r_data[2]);
        end
        tick(); #1;
        checks++;
        if (wr_owner !== 4'b0000 || rd_owner !== 4'b0000) begin
            failures++;
            $display("FAIL conc_final_idle wr=%b rd=%b exp 0000/0000", wr_owner, rd_owner);
        end
    endtask

    task automatic test_mid_reset();
        int unsigned b0;
        do_reset();
        h_aw_valid[0] = 1'b1; h_w_valid[0] = 1'b1; h_b_ready = '1;
        d_aw_ready = 1'b1; d_w_ready = 1'b1; d_b_valid = 1'b1;
        tick();
        tick();
        h_aw_valid[0] = 1'b0; h_w_valid[0] = 1'b0;
        tick();
        h_aw_valid[1] = 1'b1; h_w_valid[1] = 1'b1; d_b_valid = 1'b0;
        tick();
        tick();
        h_aw_valid[1] = 1'b0; h_w_valid[1] = 1'b0; d_b_valid = 1'b1;
        #1;
        checks++;
        if (device_if.b_ready !== 1'b1 || h_b_valid !== 4'b0010) begin
            failures++;
            $display("FAIL mid_precondition b_ready=%b b_valid=%b exp 1/0010", device_if.b_ready, h_b_valid);
        end
        b0 = host_b_cnt;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (device_if.b_ready !== 1'b0 || h_b_valid !== 4'b0000 || wr_owner !== 4'b0000) begin
            failures++;
            $display("FAIL mid_async_clear b_ready=%b b_valid=%b owner=%b exp 0/0000/0000", device_if.b_ready, h_b_valid, wr_owner);
        end
        tick();
        checks++;
        if (host_b_cnt !== b0) begin
            failures++;
            $display("FAIL mid_no_b_delivered count=%0d exp=%0d", host_b_cnt, b0);
        end
        rst = 1'b0;
        d_b_valid = 1'b0;
        h_aw_valid[0] = 1'b1; h_aw_valid[1] = 1'b1; h_w_valid[0] = 1'b1; h_w_valid[1] = 1'b1;
        tick(); #1;
        checks++;
        if (wr_owner !== 4'b0001) begin
            failures++;
            $display("FAIL mid_ptr_reset owner=%b exp=0001", wr_owner);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        aw_hs_cnt = 0;
        w_hs_cnt = 0;
        host_b_cnt = 0;
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_write();
        test_w_before_aw();
        test_round_robin();
        test_concurrent();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Round-robin arbiter sharing one AXI-Lite slave port among `NUM_MASTERS` AXI-Lite masters. Write and read paths arbitrate independently, and each path allows one outstanding transaction. It sits between CPU/DMA-side masters and a single peripheral or interconnect port. Address, data and protection fields pass through unchanged; only the handshakes are gated by the current grant.

## Interface

Parameters:
- `NUM_MASTERS`, 2, number of upstream masters; fatal assertion if < 2.
- `ADDR_WIDTH`, 48, must match all attached `axi_lite_channel` instances.
- `DATA_WIDTH`, 64, 32 or 64; must match all attached channels.

Ports:
- `clk`  input  1  clock for all state; the interfaces' own clk/rstn are not used.
- `rst`  input  1  asynchronous, active-high reset.
- `host`  modport  `axi_lite_channel.slave` [NUM_MASTERS]  upstream masters connect here.
- `device`  modport  `axi_lite_channel.master`  downstream shared slave.
- `wr_owner`  output  NUM_MASTERS  one-hot owner of the write path; 0 when the write path is idle.
- `rd_owner`  output  NUM_MASTERS  one-hot owner of the read path; 0 when the read path is idle.

## Operation

Write FSM states:
- **W_IDLE**
  - If any `host[i].aw_valid` is high, grant the first requester searching from `wr_ptr` upward, modulo NUM_MASTERS.
  - Register the grant and go to W_ADDR.
  - The W channel alone never requests.
- **W_ADDR**
  - Forward AW and W of the granted host to `device`. Ready flows back to that host only.
  - Flags `aw_done` and `w_done` are set on the respective `device` handshakes and may complete in either order or together.
  - Once a channel's flag is set, its forwarded valid is forced to 0.
  - When both are done, or will be done this cycle, go to W_RESP.
- **W_RESP**
  - Route `device.b_*` to the granted host and drive `device.b_ready` from it.
  - On the B handshake: set `wr_ptr` = grant+1 (wrapping to 0 after NUM_MASTERS-1), clear the flags and go to W_IDLE.

Read FSM, same structure:
- **R_IDLE**: pick a requester by `ar_valid` from `rd_ptr`.
- **R_ADDR**: forward AR; on the `device` AR handshake go to R_RESP.
- **R_RESP**: route R; on the R handshake set `rd_ptr` = grant+1 and go to R_IDLE.

Non-granted hosts and idle paths:
- Non-granted hosts see `aw_ready`/`w_ready`/`ar_ready` = 0 and `b_valid`/`r_valid` = 0.
- Their `b_resp`/`r_resp`/`r_data` are don't-care; they are driven 0.
- In idle states all `device` valids and `device.b_ready`/`r_ready` are 0.

Forwarding is combinational from registered state plus the live channel signals, with no storage of payload. A host must hold its payload stable per AXI rules.

A host may own both paths simultaneously. The two FSMs share no state.

## Timing

- Reset (asynchronous, immediate):
  - FSMs go to W_IDLE/R_IDLE; `wr_ptr` = `rd_ptr` = 0; flags cleared.
  - `wr_owner` = `rd_owner` = 0.
  - Every `device` valid/ready output is 0 and every `host` ready/valid output is 0.
- Reset asserted mid-transaction abandons it with no response generated. Upstream and downstream are expected to be reset together.
- Arbitration latency:
  - A request first seen in cycle N gives `device.aw_valid`/`ar_valid` high in cycle N+1, or later if the path is busy.
  - Minimum write cycle is 3 clocks: IDLE, ADDR (AW+W accepted together), RESP (B same cycle). Minimum read cycle is 3 clocks.
- Back-to-back: the next grant is evaluated in the IDLE cycle after the response handshake, so there is one idle bubble between transactions.
- Fairness: after owner k completes, owner k has lowest priority. Each of N continuously requesting hosts is served once per N transactions.
- `owner` outputs are registered: high from the ADDR cycle through the RESP handshake cycle inclusive.
- Requests arriving while the path is busy wait; a host's `aw_valid` stays high with `aw_ready` low.

## Test plan

- **Reset**: hold `rst`=1 with all hosts asserting valids. Required: all `device` valids 0, all host readies 0, owners 0. Release `rst`: `device.aw_valid`=1 one cycle after the first sampled request, with host 0 granted.
- **Single write**: host 1 writes addr 0x40, data 0x1234, strb 0xFF; the slave accepts AW and W in the same cycle and returns OKAY one cycle later. Required: `device.aw_addr`=0x40, host 1 receives `b_valid` with OKAY, `wr_owner`=0b10 during the transaction, then 0.
- **W before AW**: host 0 presents W two cycles before AW while the slave holds `aw_ready` low for 3 cycles. Required: W accepted once and forwarded valid deasserted after acceptance; RESP is entered only after the AW handshake.
- **Round-robin**: NUM_MASTERS=4, all hosts issue continuous reads. Required: grant order 0,1,2,3,0,1. Each read is served as soon as its AR is accepted, and no host is served twice before the others.
- **Concurrent read/write**: host 0 writes while host 1 reads; then host 2 does both at once. Required: both paths are active in the same cycles with owners correct, and no cross-routing of B/R responses.
- **Mid-transaction reset**: assert `rst` while the write FSM is in W_RESP with `b_valid` pending. Required: same-cycle `device.b_ready`=0, no B delivered upstream, `wr_ptr`=0 after reset.
